// File: rtl/sound_event_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sound_event_sequencer
// Brief    : Queues one-cycle sound requests (4-deep FIFO) and drives the
//            melody player's sound_code/play_sound pair. Each sound is held
//            for its full melody length, then followed by a silent gap.
//            Code 7 (game over) flushes the queue and pre-empts anything.
// Revision : 1.0 - initial release
// ============================================================================
module sound_event_sequencer #(
    parameter int STEP_CYCLES = 6250002,
    parameter int LONG_STEPS  = 64,
    parameter int SHORT_STEPS = 48,
    parameter int GAP_CYCLES  = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ev_req,
    input  logic [2:0] ev_code,
    output logic [2:0] sound_code,
    output logic       play_sound,
    output logic       busy,
    output logic [2:0] queue_level,
    output logic       overflow
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_play  = 2'd1;
    localparam logic [1:0] c_st_gap   = 2'd2;
    localparam logic [1:0] c_st_abort = 2'd3;

    localparam logic [23:0] c_step_last  = 24'(STEP_CYCLES - 1);
    localparam logic [23:0] c_gap_last   = 24'(GAP_CYCLES - 1);
    localparam logic [6:0]  c_long_last  = 7'(LONG_STEPS - 1);
    localparam logic [6:0]  c_short_last = 7'(SHORT_STEPS - 1);

    logic [1:0]  r_state;
    logic [2:0]  r_sound_code;
    logic        r_play;
    logic [2:0]  r_cur_code;   // code owning PLAY/GAP (sound_code reads 0 in GAP)
    logic [23:0] r_step_cnt;
    logic [6:0]  r_step_idx;
    logic [23:0] r_gap_cnt;
    logic        r_busy;
    logic        r_overflow;

    logic [2:0]  r_mem [4];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_count;

    logic        w_seven_active;
    logic        w_preempt;
    logic        w_push_req;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;
    logic [6:0]  w_n_last;

    logic [1:0]  w_state_nx;
    logic [2:0]  w_sound_code_nx;
    logic        w_play_nx;
    logic [2:0]  w_cur_code_nx;
    logic [23:0] w_step_cnt_nx;
    logic [6:0]  w_step_idx_nx;
    logic [23:0] w_gap_cnt_nx;
    logic [1:0]  w_wr_ptr_nx;
    logic [1:0]  w_rd_ptr_nx;
    logic [2:0]  w_count_nx;

    // Request classification and FIFO push/pop arbitration.
    always_comb begin
        w_seven_active = ((r_state == c_st_play) || (r_state == c_st_gap)) && (r_cur_code == 3'd7);
        w_preempt      = ev_req && (ev_code == 3'd7) && !w_seven_active;
        w_push_req     = ev_req && (ev_code != 3'd0) && (ev_code != 3'd7) && !w_seven_active;
        w_pop          = (r_state == c_st_idle) && (r_count != 3'd0) && !w_preempt;
        // A full FIFO still accepts a push when the head leaves on the same edge.
        w_push         = w_push_req && ((r_count != 3'd4) || w_pop);
        w_drop         = w_push_req && (r_count == 3'd4) && !w_pop;
        w_n_last       = (r_cur_code == 3'd1) ? c_long_last : c_short_last;
    end

    // Next-state, output and counter logic for the sequencer FSM and FIFO pointers.
    always_comb begin
        w_state_nx      = r_state;
        w_sound_code_nx = r_sound_code;
        w_play_nx       = r_play;
        w_cur_code_nx   = r_cur_code;
        w_step_cnt_nx   = r_step_cnt;
        w_step_idx_nx   = r_step_idx;
        w_gap_cnt_nx    = r_gap_cnt;
        w_wr_ptr_nx     = r_wr_ptr + {1'b0, w_push};
        w_rd_ptr_nx     = r_rd_ptr + {1'b0, w_pop};
        w_count_nx      = r_count + {2'b00, w_push} - {2'b00, w_pop};

        if (w_preempt) begin
            // Flush the queue and spend one silent cycle before game over plays.
            w_rd_ptr_nx     = r_wr_ptr;
            w_count_nx      = 3'd0;
            w_state_nx      = c_st_abort;
            w_sound_code_nx = 3'd0;
            w_play_nx       = 1'b0;
            w_cur_code_nx   = 3'd7;
            w_step_cnt_nx   = '0;
            w_step_idx_nx   = '0;
            w_gap_cnt_nx    = '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_pop) begin
                        w_state_nx      = c_st_play;
                        w_sound_code_nx = r_mem[r_rd_ptr];
                        w_cur_code_nx   = r_mem[r_rd_ptr];
                        w_play_nx       = 1'b1;
                        w_step_cnt_nx   = '0;
                        w_step_idx_nx   = '0;
                        w_gap_cnt_nx    = '0;
                    end
                end
                c_st_play: begin
                    if (r_step_cnt == c_step_last) begin
                        w_step_cnt_nx = '0;
                        if (r_step_idx == w_n_last) begin
                            w_step_idx_nx   = '0;
                            w_state_nx      = c_st_gap;
                            w_sound_code_nx = 3'd0;
                            w_play_nx       = 1'b0;
                        end else begin
                            w_step_idx_nx = r_step_idx + 7'd1;
                        end
                    end else begin
                        w_step_cnt_nx = r_step_cnt + 24'd1;
                    end
                end
                c_st_gap: begin
                    if (r_gap_cnt == c_gap_last) begin
                        w_gap_cnt_nx = '0;
                        w_state_nx   = c_st_idle;
                    end else begin
                        w_gap_cnt_nx = r_gap_cnt + 24'd1;
                    end
                end
                default: begin
                    w_state_nx      = c_st_play;
                    w_sound_code_nx = 3'd7;
                    w_cur_code_nx   = 3'd7;
                    w_play_nx       = 1'b1;
                    w_step_cnt_nx   = '0;
                    w_step_idx_nx   = '0;
                    w_gap_cnt_nx    = '0;
                end
            endcase
        end
    end

    // State, counters, FIFO storage and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_sound_code <= 3'd0;
            r_play       <= 1'b0;
            r_cur_code   <= 3'd0;
            r_step_cnt   <= '0;
            r_step_idx   <= '0;
            r_gap_cnt    <= '0;
            r_busy       <= 1'b0;
            r_overflow   <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= 3'd0;
            end
        end else begin
            r_state      <= w_state_nx;
            r_sound_code <= w_sound_code_nx;
            r_play       <= w_play_nx;
            r_cur_code   <= w_cur_code_nx;
            r_step_cnt   <= w_step_cnt_nx;
            r_step_idx   <= w_step_idx_nx;
            r_gap_cnt    <= w_gap_cnt_nx;
            // busy lags the state and queue by one cycle.
            r_busy       <= (r_state != c_st_idle) || (r_count != 3'd0);
            r_overflow   <= w_drop;
            r_wr_ptr     <= w_wr_ptr_nx;
            r_rd_ptr     <= w_rd_ptr_nx;
            r_count      <= w_count_nx;
            if (w_push) begin
                r_mem[r_wr_ptr] <= ev_code;
            end
        end
    end

    assign sound_code  = r_sound_code;
    assign play_sound  = r_play;
    assign busy        = r_busy;
    assign queue_level = r_count;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_sound_event_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sound_event_sequencer
// Brief    : Directed self-checking bench for sound_event_sequencer with
//            STEP_CYCLES=4, SHORT_STEPS=48, LONG_STEPS=64, GAP_CYCLES=3.
//            Short sounds last 192 cycles, code 1 lasts 256 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sound_event_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ev_req = 1'b0;
    logic [2:0] ev_code = 3'd0;
    logic [2:0] sound_code;
    logic       play_sound;
    logic       busy;
    logic [2:0] queue_level;
    logic       overflow;

    int n_checks = 0;
    int n_fails  = 0;

    sound_event_sequencer #(
        .STEP_CYCLES (4),
        .LONG_STEPS  (64),
        .SHORT_STEPS (48),
        .GAP_CYCLES  (3)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .ev_req      (ev_req),
        .ev_code     (ev_code),
        .sound_code  (sound_code),
        .play_sound  (play_sound),
        .busy        (busy),
        .queue_level (queue_level),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Safety net in case a bounded loop is bypassed.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // All sampling and driving happens on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    // Present one request for exactly one rising edge; returns at the sample after it.
    task automatic send(input logic [2:0] c);
        ev_req  = 1'b1;
        ev_code = c;
        tick();
        ev_req  = 1'b0;
        ev_code = 3'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    // Counts low samples up to the next sound, then that sound's high samples.
    task automatic measure(output int low, output int high, output int code);
        low  = 0;
        high = 0;
        while (!play_sound && low < 2000) begin
            low++;
            tick();
        end
        code = int'(sound_code);
        while (play_sound && high < 2000) begin
            high++;
            tick();
        end
    endtask

    initial begin
        int lo, hi, cd, peak, ovf_cnt, n;

        // Reset state
        tick();
        check("rst_play", play_sound, 0);
        check("rst_code", sound_code, 0);
        check("rst_busy", busy, 0);
        check("rst_level", queue_level, 0);
        check("rst_ovf", overflow, 0);
        do_reset();

        // Code 0 is ignored
        send(3'd0);
        check("code0_level", queue_level, 0);
        check("code0_ovf", overflow, 0);
        tick();
        check("code0_busy", busy, 0);

        // 1. Single sound with E1 latency
        send(3'd3);
        check("t1_level_after_push", queue_level, 1);
        check("t1_play_at_e0", play_sound, 0);
        measure(lo, hi, cd);
        check("t1_latency_low", lo, 1);
        check("t1_high_len", hi, 192);
        check("t1_code", cd, 3);
        repeat (3) tick();
        check("t1_busy_lag", busy, 1);
        tick();
        check("t1_busy_clear", busy, 0);
        check("t1_still_silent", play_sound, 0);

        // 2. Queue ordering 1, 2, 4
        do_reset();
        send(3'd1);
        peak = int'(queue_level);
        send(3'd2);
        if (int'(queue_level) > peak) peak = int'(queue_level);
        check("t2_first_code", sound_code, 1);
        send(3'd4);
        if (int'(queue_level) > peak) peak = int'(queue_level);
        check("t2_peak", peak, 2);
        measure(lo, hi, cd);
        check("t2_s1_low", lo, 0);
        check("t2_s1_rest", hi, 255);
        check("t2_s1_code", cd, 1);
        measure(lo, hi, cd);
        check("t2_s2_gap", lo, 4);
        check("t2_s2_len", hi, 192);
        check("t2_s2_code", cd, 2);
        measure(lo, hi, cd);
        check("t2_s3_gap", lo, 4);
        check("t2_s3_len", hi, 192);
        check("t2_s3_code", cd, 4);

        // 3. Overflow while code 6 plays
        do_reset();
        send(3'd6);
        tick();
        check("t3_play6", sound_code, 6);
        ovf_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            send(3'd5);
            ovf_cnt += int'(overflow);
        end
        check("t3_level", queue_level, 4);
        tick();
        ovf_cnt += int'(overflow);
        check("t3_ovf_pulses", ovf_cnt, 2);

        // 6. Push onto full FIFO on the IDLE pop edge
        n = 0;
        while (play_sound && n < 500) begin
            n++;
            tick();
        end
        repeat (3) tick();
        check("t6_level_before", queue_level, 4);
        check("t6_silent_before", play_sound, 0);
        send(3'd3);
        check("t6_play", play_sound, 1);
        check("t6_code", sound_code, 5);
        check("t6_level_kept", queue_level, 4);
        check("t6_no_ovf", overflow, 0);

        // 4. Pre-emption by code 7
        do_reset();
        send(3'd1);
        send(3'd2);
        send(3'd3);
        send(3'd4);
        check("t4_level3", queue_level, 3);
        repeat (100) tick();
        check("t4_mid_code1", sound_code, 1);
        send(3'd7);
        check("t4_abort_play", play_sound, 0);
        check("t4_abort_code", sound_code, 0);
        check("t4_flushed", queue_level, 0);
        tick();
        check("t4_play7", play_sound, 1);
        check("t4_code7", sound_code, 7);
        repeat (50) tick();
        send(3'd4);
        check("t4_drop_no_ovf", overflow, 0);
        check("t4_drop_level", queue_level, 0);
        send(3'd7);
        check("t4_seven_ignored", sound_code, 7);
        measure(lo, hi, cd);
        check("t4_rest_len", hi, 140);
        check("t4_rest_code", cd, 7);
        repeat (10) tick();
        check("t4_idle_after", play_sound, 0);
        check("t4_busy_after", busy, 0);

        // 5. Asynchronous reset mid-sound
        do_reset();
        send(3'd3);
        repeat (20) tick();
        check("t5_playing", play_sound, 1);
        send(3'd4);
        check("t5_level_pre", queue_level, 1);
        #2 rst = 1'b1;
        #1;
        check("t5_async_play", play_sound, 0);
        check("t5_async_code", sound_code, 0);
        check("t5_async_busy", busy, 0);
        check("t5_async_level", queue_level, 0);
        @(negedge clk);
        rst = 1'b0;
        send(3'd2);
        check("t5_level_post", queue_level, 1);
        measure(lo, hi, cd);
        check("t5_latency_low", lo, 1);
        check("t5_len", hi, 192);
        check("t5_code", cd, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
